pipe_control: RTL

- Pipeline control unit for the five-stage Y86-64 core; owns the F-stage PC register (F_predPC) feeding the fetch stage.
- Generates per-stage stall/bubble controls for load/use hazards, ret handling, mispredicted jumps and exceptions.
- Runs a run/halt state machine and performance counters; this is the single point that sequences the fetch datapath.

---
 rtl/pipe_control.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipe_control.sv
// Y86-64 pipeline control: hazard stall/bubble generation, fetch PC register, run/halt FSM, perf counters.
// Latency: stall/bubble/set_cc_en are combinational; F_predPC, state, cpu_stat and counters update on the next clk edge.
// Backpressure: none accepted; this block is the source of all pipeline stalls and bubbles.
module pipe_control #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          BOOT_CYCLES = 2,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      f_predPC,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [2:0]       W_stat,
    output logic [63:0]      F_predPC,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc_en,
    output logic [1:0]       state,
    output logic [2:0]       cpu_stat,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] boot_cnt;

    logic lu;
    logic rt;
    logic mp;
    logic ex_m;
    logic ex_w;
    logic instr_retired;

    always_comb begin
        lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
             (E_dstM != R_NONE) &&
             ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mp = (E_icode == I_JXX) && !e_cnd;
        ex_m = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
        ex_w = (W_stat == S_HLT) || (W_stat == S_ADR) || (W_stat == S_INS);
        instr_retired = (W_stat == S_AOK) && (W_icode != I_NOP);
    end

    always_comb begin
        state_d   = state_q;
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        W_stall   = 1'b0;
        D_bubble  = 1'b0;
        E_bubble  = 1'b0;
        M_bubble  = 1'b0;
        set_cc_en = 1'b0;
        case (state_q)
            ST_BOOT: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                if (boot_cnt == BOOT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                F_stall   = lu | rt;
                D_stall   = lu;
                // load/use dominates ret so D holds its instruction instead of losing it
                D_bubble  = mp | (rt & ~lu);
                E_bubble  = mp | lu;
                M_bubble  = ex_m | ex_w;
                W_stall   = ex_w;
                set_cc_en = (E_icode == I_OPQ) & ~ex_m & ~ex_w;
                if (ex_w) begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                F_stall = 1'b1;
                D_stall = 1'b1;
                W_stall = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            boot_cnt    <= 4'd0;
            F_predPC    <= RESET_PC;
            cpu_stat    <= S_AOK;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_BOOT) begin
                boot_cnt <= boot_cnt + 4'd1;
            end
            if (state_q == ST_RUN) begin
                if (!F_stall) begin
                    F_predPC <= f_predPC;
                end
                if (ex_w) begin
                    cpu_stat <= W_stat;
                end
                if (!(&cycle_count)) begin
                    cycle_count <= cycle_count + CNT_W'(1);
                end
                if (instr_retired && !(&instr_count)) begin
                    instr_count <= instr_count + CNT_W'(1);
                end
            end
        end
    end

    assign state = state_q;

endmodule
